// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : PC, single-outstanding imem requester and IF/ID register with
//            stall/flush/redirect. Optional macro FETCH_PERF_EN adds counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [1:0]  pc_src_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] jr_addr_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_discard_cnt_o
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [1:0] c_PC_JUMP = 2'b01;
  localparam logic [1:0] c_PC_JR   = 2'b10;

  state_t      r_state, w_nextState;
  logic [31:0] r_pc, w_nextPc;
  logic [31:0] r_addr, w_nextAddr;
  logic        r_req, w_nextReq;
  logic [31:0] r_buf, w_nextBuf;
  logic [31:0] r_ifidInstr, w_nextInstr;
  logic [31:0] r_ifidPc4, w_nextPc4;
  logic        r_ifidValid, w_nextValid;

  logic        w_redirect;
  logic        w_hold;
  logic [31:0] w_target;
  logic [31:0] w_seqPc;
  logic [31:0] w_discardPc;
  logic        w_deliver;
  logic [31:0] w_deliverInstr;

  assign w_redirect = !stall_i &&
                      (branch_taken_i || pc_src_i == c_PC_JUMP || pc_src_i == c_PC_JR);
  // A flush without a redirect must not lose the arriving word, so it parks it like a stall.
  assign w_hold      = stall_i || flush_i;
  assign w_seqPc     = r_addr + 32'd4;
  assign w_discardPc = w_redirect ? w_target : r_pc;

  always_comb begin
    if (branch_taken_i) begin
      w_target = branch_target_i;
    end else if (pc_src_i == c_PC_JUMP) begin
      w_target = {r_ifidPc4[31:28], jump_index_i, 2'b00};
    end else begin
      w_target = jr_addr_i;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextPc       = r_pc;
    w_nextAddr     = r_addr;
    w_nextReq      = r_req;
    w_nextBuf      = r_buf;
    w_deliver      = 1'b0;
    w_deliverInstr = imem_rdata_i;
    case (r_state)
      FETCH: begin
        w_nextReq = 1'b1;
        if (imem_valid_i) begin
          if (w_redirect) begin
            w_nextPc   = w_target;
            w_nextAddr = w_target;
          end else if (w_hold) begin
            w_nextBuf   = imem_rdata_i;
            w_nextState = HOLD;
            w_nextReq   = 1'b0;
          end else begin
            w_deliver  = 1'b1;
            w_nextPc   = w_seqPc;
            w_nextAddr = w_seqPc;
          end
        end else if (w_redirect) begin
          w_nextPc = w_target;
          // With nothing issued yet (first cycle out of reset) there is no stale word to wait for.
          if (r_req) begin
            w_nextState = DISCARD;
          end else begin
            w_nextAddr = w_target;
          end
        end
      end
      HOLD: begin
        w_deliverInstr = r_buf;
        if (w_redirect) begin
          w_nextPc    = w_target;
          w_nextAddr  = w_target;
          w_nextReq   = 1'b1;
          w_nextState = FETCH;
        end else if (!w_hold) begin
          w_deliver   = 1'b1;
          w_nextPc    = w_seqPc;
          w_nextAddr  = w_seqPc;
          w_nextReq   = 1'b1;
          w_nextState = FETCH;
        end
      end
      DISCARD: begin
        w_nextPc = w_discardPc;
        if (imem_valid_i) begin
          w_nextAddr  = w_discardPc;
          w_nextState = FETCH;
        end
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  always_comb begin
    w_nextInstr = 32'd0;
    w_nextPc4   = 32'd0;
    w_nextValid = 1'b0;
    if (flush_i || w_redirect) begin
      w_nextInstr = 32'd0;
      w_nextPc4   = 32'd0;
      w_nextValid = 1'b0;
    end else if (stall_i) begin
      w_nextInstr = r_ifidInstr;
      w_nextPc4   = r_ifidPc4;
      w_nextValid = r_ifidValid;
    end else if (w_deliver) begin
      w_nextInstr = w_deliverInstr;
      w_nextPc4   = w_seqPc;
      w_nextValid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_req       <= 1'b0;
      r_buf       <= 32'd0;
      r_ifidInstr <= 32'd0;
      r_ifidPc4   <= 32'd0;
      r_ifidValid <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_pc        <= w_nextPc;
      r_addr      <= w_nextAddr;
      r_req       <= w_nextReq;
      r_buf       <= w_nextBuf;
      r_ifidInstr <= w_nextInstr;
      r_ifidPc4   <= w_nextPc4;
      r_ifidValid <= w_nextValid;
    end
  end

  assign imem_req_o   = r_req;
  assign imem_addr_o  = r_addr;
  assign ifid_instr_o = r_ifidInstr;
  assign ifid_pc4_o   = r_ifidPc4;
  assign ifid_valid_o = r_ifidValid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_discardCnt;
  logic        w_drop;

  assign w_drop = (r_state == FETCH   && imem_valid_i && w_redirect) ||
                  (r_state == HOLD    && w_redirect) ||
                  (r_state == DISCARD && imem_valid_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCnt   <= 32'd0;
      r_discardCnt <= 32'd0;
    end else begin
      if (r_state == FETCH && !imem_valid_i) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
      if (w_drop) begin
        r_discardCnt <= r_discardCnt + 32'd1;
      end
    end
  end

  assign perf_stall_cnt_o   = r_stallCnt;
  assign perf_discard_cnt_o = r_discardCnt;
`else
  assign perf_stall_cnt_o   = 32'd0;
  assign perf_discard_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed bench for fetch_stage with a variable-latency imem that
//            returns the request address as data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [1:0]  pcSrc;
  logic [25:0] jumpIdx;
  logic [31:0] jrAddr;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemValid;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPc4;
  logic        ifidValid;
  logic [31:0] stallCnt;
  logic [31:0] discardCnt;

  int lat;
  int memCnt;
  int testCount = 0;
  int failCount = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_i            (stall),
    .flush_i            (flush),
    .pc_src_i           (pcSrc),
    .jump_index_i       (jumpIdx),
    .jr_addr_i          (jrAddr),
    .branch_taken_i     (brTaken),
    .branch_target_i    (brTarget),
    .imem_req_o         (imemReq),
    .imem_addr_o        (imemAddr),
    .imem_rdata_i       (imemRdata),
    .imem_valid_i       (imemValid),
    .ifid_instr_o       (ifidInstr),
    .ifid_pc4_o         (ifidPc4),
    .ifid_valid_o       (ifidValid),
    .perf_stall_cnt_o   (stallCnt),
    .perf_discard_cnt_o (discardCnt)
  );

  always #5 clk = ~clk;

  // Latency counts the cycles of a request including its first; 1 answers in the issue cycle.
  assign imemValid = imemReq && (memCnt == lat - 1);
  assign imemRdata = imemAddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) memCnt <= 0;
    else if (imemReq && !imemValid) memCnt <= memCnt + 1;
    else memCnt <= 0;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfid(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
    checkVal({tag, "_instr"}, ifidInstr, instr);
    checkVal({tag, "_pc4"}, ifidPc4, pc4);
    checkVal({tag, "_valid"}, {31'd0, ifidValid}, 32'd1);
  endtask

  task automatic checkBubble(input string tag);
    checkVal({tag, "_binstr"}, ifidInstr, 32'd0);
    checkVal({tag, "_bvalid"}, {31'd0, ifidValid}, 32'd0);
  endtask

  task automatic checkBus(input string tag, input logic req, input logic [31:0] addr);
    checkVal({tag, "_req"}, {31'd0, imemReq}, {31'd0, req});
    checkVal({tag, "_addr"}, imemAddr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; pcSrc = 2'b00; jumpIdx = 26'd0;
    jrAddr = 32'd0; brTaken = 1'b0; brTarget = 32'd0; lat = 1;
    repeat (3) tick();
    checkBus("rst", 1'b0, 32'h0040_0000);
    checkVal("rst_instr", ifidInstr, 32'd0);
    checkVal("rst_pc4", ifidPc4, 32'd0);
    checkVal("rst_valid", {31'd0, ifidValid}, 32'd0);
    checkVal("rst_stallcnt", stallCnt, 32'd0);
    checkVal("rst_discnt", discardCnt, 32'd0);

    // Reset release and back-to-back 1-cycle fetch
    rst_n = 1'b1;
    tick();
    checkBus("first", 1'b1, 32'h0040_0000);
    checkVal("first_valid", {31'd0, ifidValid}, 32'd0);
    tick();
    checkIfid("seq0", 32'h0040_0000, 32'h0040_0004);
    checkBus("seq0", 1'b1, 32'h0040_0004);
    tick();
    checkIfid("seq1", 32'h0040_0004, 32'h0040_0008);
    checkBus("seq1", 1'b1, 32'h0040_0008);

    // Stall while the response arrives
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIfid("stall", 32'h0040_0004, 32'h0040_0008);
      checkBus("stall", 1'b0, 32'h0040_0008);
    end
    stall = 1'b0;
    tick();
    checkIfid("unstall", 32'h0040_0008, 32'h0040_000C);
    checkBus("unstall", 1'b1, 32'h0040_000C);
    tick();
    checkIfid("postst", 32'h0040_000C, 32'h0040_0010);
    checkBus("postst", 1'b1, 32'h0040_0010);

    // Jump in the same cycle as a valid response
    pcSrc = 2'b01; jumpIdx = 26'h000_0010;
    tick();
    pcSrc = 2'b00;
    checkBubble("jump");
    checkBus("jump", 1'b1, 32'h0000_0040);
    tick();
    checkIfid("jtgt", 32'h0000_0040, 32'h0000_0044);
    checkBus("jtgt", 1'b1, 32'h0000_0044);

    // 3-cycle latency, branch taken while waiting
    lat = 3;
    tick();
    checkBubble("wait");
    checkBus("wait", 1'b1, 32'h0000_0044);
    brTaken = 1'b1; brTarget = 32'h0040_0100;
    tick();
    brTaken = 1'b0;
    checkBubble("br");
    checkBus("br", 1'b1, 32'h0000_0044);
    tick();
    checkBubble("drop");
    checkBus("drop", 1'b1, 32'h0040_0100);
    tick();
    checkBubble("btw1");
    tick();
    checkBubble("btw2");
    tick();
    checkIfid("btgt", 32'h0040_0100, 32'h0040_0104);
    checkVal("perf_stall", stallCnt, PERF ? 32'd5 : 32'd0);
    checkVal("perf_disc", discardCnt, PERF ? 32'd2 : 32'd0);

    // Flush together with stall
    lat = 1; stall = 1'b1; flush = 1'b1;
    tick();
    checkBubble("flush");
    checkBus("flush", 1'b0, 32'h0040_0104);
    stall = 1'b0; flush = 1'b0;
    tick();
    checkIfid("postfl", 32'h0040_0104, 32'h0040_0108);
    checkBus("postfl", 1'b1, 32'h0040_0108);

    // jr to the top of the address space, then wrap
    pcSrc = 2'b10; jrAddr = 32'hFFFF_FFFC;
    tick();
    pcSrc = 2'b00;
    checkBubble("jr");
    checkBus("jr", 1'b1, 32'hFFFF_FFFC);
    tick();
    checkIfid("wrap", 32'hFFFF_FFFC, 32'h0000_0000);
    checkBus("wrap", 1'b1, 32'h0000_0000);
    tick();
    checkIfid("wrap1", 32'h0000_0000, 32'h0000_0004);
    checkBus("wrap1", 1'b1, 32'h0000_0004);

    // Two redirects while discarding: the newest target wins
    lat = 3; brTaken = 1'b1; brTarget = 32'h0000_1000;
    tick();
    checkBubble("disc1");
    checkBus("disc1", 1'b1, 32'h0000_0004);
    brTarget = 32'h0000_2000;
    tick();
    brTaken = 1'b0;
    checkBubble("disc2");
    checkBus("disc2", 1'b1, 32'h0000_0004);
    tick();
    checkBubble("disc3");
    checkBus("disc3", 1'b1, 32'h0000_2000);
    repeat (3) tick();
    checkIfid("newest", 32'h0000_2000, 32'h0000_2004);

    // Asynchronous reset mid-request
    #2 rst_n = 1'b0;
    #1;
    checkBus("arst", 1'b0, 32'h0040_0000);
    checkBubble("arst");
    checkVal("arst_pc4", ifidPc4, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
`default_nettype wire
